burst_ram: RTL and testbench

- Next-generation synchronous RAM for the caching system. Serves whole cache lines as bursts of BURST_LEN words behind a valid/ready request handshake.
- Has a programmable access latency and wrap-around, critical-word-first addressing.
- Uses separate read and write data paths; no tri-state bus.
- Sits between the cache controller's line-fill/write-back engine and backing storage.

---
 rtl/burst_ram_pkg.sv | 17 +
 rtl/burst_ram_array.sv | 55 +++++
 rtl/burst_ram.sv | 150 +++++++++++++++
 tb/tb_burst_ram.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_ram_pkg.sv
// Shared types for the burst RAM: controller state encoding and the
// beat-index width helper.
package burst_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RBURST,
    WBURST,
    DONE
  } state_t;

  function automatic int beat_bits(input int burstLen);
    return $clog2(burstLen);
  endfunction

endpackage

// File: rtl/burst_ram_array.sv
// Single-port synchronous word store with registered read port.
// Defining RAM_PARITY_EN adds an even-parity column checked on every read.
module burst_ram_array #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  parity_bad_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef RAM_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rword_q;
  logic [WORD_W-1:0] storeWord;

`ifdef RAM_PARITY_EN
  // Stored bit makes the whole word even, so a clean word XORs to zero.
  assign storeWord    = {^wdata_i, wdata_i};
  assign parity_bad_o = ^rword_q;
`else
  assign storeWord    = wdata_i;
  assign parity_bad_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= storeWord;
    end
  end

  // Storage is never cleared; only the read register resets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rword_q <= '0;
    end else if (re_i) begin
      rword_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rword_q[DATA_WIDTH-1:0];

endmodule

// File: rtl/burst_ram.sv
// Burst RAM controller: request handshake, access latency, wrapping
// critical-word-first bursts. Parity (RAM_PARITY_EN) lives in the array.
module burst_ram
  import burst_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int BURST_LEN      = 4,
  parameter int ACCESS_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  done,
  output logic                  busy,
  output logic                  parity_err
);

  localparam int BB = beat_bits(BURST_LEN);
  localparam int LW = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_LOAD  = (ACCESS_LATENCY > 0) ? LW'(ACCESS_LATENCY - 1) : '0;
  localparam logic [BB-1:0] LAST_BEAT = BB'(BURST_LEN - 1);

  state_t                state_q, state_d;
  logic [BB-1:0]         beat_q, beat_d;
  logic [LW-1:0]         waitCnt_q, waitCnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  isWrite_q, isWrite_d;
  logic                  rdValid_q;
  logic                  parityErr_q;
  logic                  memWe, memRe, parityBad;
  logic [BB-1:0]         wrapOffset;
  logic [ADDR_WIDTH-1:0] memAddr;

  // Offset arithmetic is BB bits wide, so it wraps inside the aligned line.
  assign wrapOffset = addr_q[BB-1:0] + beat_q;

  generate
    if (BB == ADDR_WIDTH) begin : g_whole_space
      assign memAddr = wrapOffset;
    end else begin : g_line
      assign memAddr = {addr_q[ADDR_WIDTH-1:BB], wrapOffset};
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    waitCnt_d = waitCnt_q;
    addr_d    = addr_q;
    isWrite_d = isWrite_q;
    memWe     = 1'b0;
    memRe     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          isWrite_d = req_write;
          beat_d    = '0;
          waitCnt_d = LAT_LOAD;
          if (ACCESS_LATENCY > 0) begin
            state_d = WAIT;
          end else begin
            state_d = req_write ? WBURST : RBURST;
          end
        end
      end
      WAIT: begin
        if (waitCnt_q == '0) begin
          state_d = isWrite_q ? WBURST : RBURST;
        end else begin
          waitCnt_d = waitCnt_q - 1'b1;
        end
      end
      RBURST: begin
        memRe  = 1'b1;
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = DONE;
        end
      end
      WBURST: begin
        if (wdata_valid) begin
          memWe  = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      waitCnt_q   <= '0;
      addr_q      <= '0;
      isWrite_q   <= 1'b0;
      rdValid_q   <= 1'b0;
      parityErr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      waitCnt_q   <= waitCnt_d;
      addr_q      <= addr_d;
      isWrite_q   <= isWrite_d;
      rdValid_q   <= (state_q == RBURST);
      parityErr_q <= parityErr_q | (rdValid_q & parityBad);
    end
  end

  burst_ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .we_i        (memWe),
    .re_i        (memRe),
    .addr_i      (memAddr),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .parity_bad_o(parityBad)
  );

  // Ready is gated by rst so it reads low for the whole reset window.
  assign req_ready   = (state_q == IDLE) && !rst;
  assign wdata_ready = (state_q == WBURST);
  assign rdata_valid = rdValid_q;
  assign done        = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign parity_err  = parityErr_q;

endmodule

// File: tb/tb_burst_ram.sv
// Directed bench for burst_ram at default parameters (latency 2, 4-beat bursts).
// The parity scenario switches on RAM_PARITY_EN.
module tb_burst_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] wdata;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        busy;
  logic        parity_err;

  int          nAssert = 0;
  int          nFail   = 0;
  logic [15:0] rdBuf [4];
  int          rdCount;
  logic        writeOk;

  always #5 clk = ~clk;

  burst_ram dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .wdata      (wdata),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .done       (done),
    .busy       (busy),
    .parity_err (parity_err)
  );

  // Called from a falling edge while idle; the next falling edge is cycle 1.
  task automatic issueReq(input logic [15:0] a, input logic w);
    req_addr  = a;
    req_write = w;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic doWrite(input logic [15:0] a, input logic [15:0] base);
    int k = 0;
    writeOk     = 1'b0;
    wdata       = base;
    wdata_valid = 1'b1;
    issueReq(a, 1'b1);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        writeOk = (k == 4);
        break;
      end
      if (wdata_ready && k < 4) begin
        wdata = base + 16'(k);
        k++;
      end
    end
    wdata_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic doRead(input logic [15:0] a);
    rdCount = 0;
    for (int i = 0; i < 4; i++) rdBuf[i] = 16'hxxxx;
    issueReq(a, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rdata_valid && rdCount < 4) begin
        rdBuf[rdCount] = rdata;
        rdCount++;
      end
      if (done) break;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    wdata       = '0;
    wdata_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nAssert++; if (req_ready !== 1'b0) begin nFail++; $display("[TB] FAIL reset_req_ready: got %b, expected 0", req_ready); end
    nAssert++; if (wdata_ready !== 1'b0) begin nFail++; $display("[TB] FAIL reset_wdata_ready: got %b, expected 0", wdata_ready); end
    nAssert++; if (rdata !== 16'h0) begin nFail++; $display("[TB] FAIL reset_rdata: got %h, expected 0000", rdata); end
    nAssert++; if (rdata_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_rdata_valid: got %b, expected 0", rdata_valid); end
    nAssert++; if (done !== 1'b0) begin nFail++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
    nAssert++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    nAssert++; if (parity_err !== 1'b0) begin nFail++; $display("[TB] FAIL reset_parity_err: got %b, expected 0", parity_err); end
    rst = 1'b0;
    @(negedge clk);
    nAssert++; if (req_ready !== 1'b1) begin nFail++; $display("[TB] FAIL post_reset_req_ready: got %b, expected 1", req_ready); end
    nAssert++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL post_reset_busy: got %b, expected 0", busy); end
  endtask

  // Accept at edge 0; WAIT in cycles 1-2, beats in 3-6, DONE in 7, idle in 8.
  task automatic test_write_burst();
    logic expReady, expDone, expBusy, expReqReady;
    int nDone = 0;
    wdata       = 16'hA000;
    wdata_valid = 1'b1;
    issueReq(16'h0010, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c >= 3) wdata = 16'hA000 + 16'(c - 3);
      expReady    = (c >= 3 && c <= 6);
      expDone     = (c == 7);
      expBusy     = (c <= 7);
      expReqReady = (c == 8);
      if (done) nDone++;
      nAssert++; if (wdata_ready !== expReady) begin nFail++; $display("[TB] FAIL wr_wdata_ready c%0d: got %b, expected %b", c, wdata_ready, expReady); end
      nAssert++; if (done !== expDone) begin nFail++; $display("[TB] FAIL wr_done c%0d: got %b, expected %b", c, done, expDone); end
      nAssert++; if (busy !== expBusy) begin nFail++; $display("[TB] FAIL wr_busy c%0d: got %b, expected %b", c, busy, expBusy); end
      nAssert++; if (req_ready !== expReqReady) begin nFail++; $display("[TB] FAIL wr_req_ready c%0d: got %b, expected %b", c, req_ready, expReqReady); end
    end
    wdata_valid = 1'b0;
    nAssert++; if (nDone != 1) begin nFail++; $display("[TB] FAIL wr_done_count: got %0d, expected 1", nDone); end
  endtask

  // Beats 0,1 in cycles 3,4; valid low 5-7; beats 2,3 in 8,9; DONE in 10.
  task automatic test_write_stall();
    logic expReady, expDone;
    logic [15:0] expLine [4];
    doWrite(16'h0024, 16'hC000);
    nAssert++; if (writeOk !== 1'b1) begin nFail++; $display("[TB] FAIL stall_prefill_write: got %b, expected 1", writeOk); end
    wdata_valid = 1'b0;
    issueReq(16'h0022, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      case (c)
        3:       begin wdata_valid = 1'b1; wdata = 16'hB000; end
        4:       begin wdata_valid = 1'b1; wdata = 16'hB001; end
        8:       begin wdata_valid = 1'b1; wdata = 16'hB002; end
        9:       begin wdata_valid = 1'b1; wdata = 16'hB003; end
        default: begin wdata_valid = 1'b0; wdata = 16'hDEAD; end
      endcase
      expReady = (c >= 3 && c <= 9);
      expDone  = (c == 10);
      nAssert++; if (wdata_ready !== expReady) begin nFail++; $display("[TB] FAIL stall_wdata_ready c%0d: got %b, expected %b", c, wdata_ready, expReady); end
      nAssert++; if (done !== expDone) begin nFail++; $display("[TB] FAIL stall_done c%0d: got %b, expected %b", c, done, expDone); end
    end
    nAssert++; if (req_ready !== 1'b1) begin nFail++; $display("[TB] FAIL stall_req_ready_after: got %b, expected 1", req_ready); end
    expLine[0] = 16'hB002; expLine[1] = 16'hB003; expLine[2] = 16'hB000; expLine[3] = 16'hB001;
    doRead(16'h0020);
    nAssert++; if (rdCount != 4) begin nFail++; $display("[TB] FAIL stall_readback_beats: got %0d, expected 4", rdCount); end
    for (int i = 0; i < 4; i++) begin
      nAssert++; if (rdBuf[i] !== expLine[i]) begin nFail++; $display("[TB] FAIL stall_word_%0h: got %h, expected %h", 16'h20 + i, rdBuf[i], expLine[i]); end
    end
    doRead(16'h0024);
    nAssert++; if (rdBuf[0] !== 16'hC000) begin nFail++; $display("[TB] FAIL stall_untouched_0024: got %h, expected C000", rdBuf[0]); end
  endtask

  // Start at 0x13 wraps to 0x10; data in cycles 4-7, done in 7.
  task automatic test_read_burst();
    logic expValid, expDone;
    logic [15:0] expData [4];
    expData[0] = 16'hA003; expData[1] = 16'hA000; expData[2] = 16'hA001; expData[3] = 16'hA002;
    issueReq(16'h0013, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      expValid = (c >= 4 && c <= 7);
      expDone  = (c == 7);
      nAssert++; if (rdata_valid !== expValid) begin nFail++; $display("[TB] FAIL rd_valid c%0d: got %b, expected %b", c, rdata_valid, expValid); end
      nAssert++; if (done !== expDone) begin nFail++; $display("[TB] FAIL rd_done c%0d: got %b, expected %b", c, done, expDone); end
      if (expValid) begin
        nAssert++; if (rdata !== expData[c - 4]) begin nFail++; $display("[TB] FAIL rd_data c%0d: got %h, expected %h", c, rdata, expData[c - 4]); end
      end
    end
    nAssert++; if (req_ready !== 1'b1) begin nFail++; $display("[TB] FAIL rd_req_ready_after: got %b, expected 1", req_ready); end
  endtask

  // Beat 0 lands at edge 3; rst rises during cycle 4 before beat 1 is taken.
  task automatic test_reset_mid_burst();
    logic [15:0] expLine [4];
    doWrite(16'h0030, 16'hD000);
    nAssert++; if (writeOk !== 1'b1) begin nFail++; $display("[TB] FAIL midrst_prefill_write: got %b, expected 1", writeOk); end
    wdata       = 16'hE000;
    wdata_valid = 1'b1;
    issueReq(16'h0030, 1'b1);
    repeat (3) @(negedge clk);
    @(negedge clk);
    wdata = 16'hE001;
    rst   = 1'b1;
    #1;
    nAssert++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_busy: got %b, expected 0", busy); end
    nAssert++; if (req_ready !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_req_ready: got %b, expected 0", req_ready); end
    nAssert++; if (wdata_ready !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_wdata_ready: got %b, expected 0", wdata_ready); end
    nAssert++; if (rdata !== 16'h0) begin nFail++; $display("[TB] FAIL midrst_rdata: got %h, expected 0000", rdata); end
    @(negedge clk);
    nAssert++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_busy_held: got %b, expected 0", busy); end
    rst         = 1'b0;
    wdata_valid = 1'b0;
    @(negedge clk);
    nAssert++; if (req_ready !== 1'b1) begin nFail++; $display("[TB] FAIL midrst_idle_after: got %b, expected 1", req_ready); end
    expLine[0] = 16'hE000; expLine[1] = 16'hD001; expLine[2] = 16'hD002; expLine[3] = 16'hD003;
    doRead(16'h0030);
    for (int i = 0; i < 4; i++) begin
      nAssert++; if (rdBuf[i] !== expLine[i]) begin nFail++; $display("[TB] FAIL midrst_word_%0h: got %h, expected %h", 16'h30 + i, rdBuf[i], expLine[i]); end
    end
  endtask

  task automatic test_parity();
`ifdef RAM_PARITY_EN
    dut.u_array.mem_q[16'h0011] = dut.u_array.mem_q[16'h0011] ^ 17'h00001;
    nAssert++; if (parity_err !== 1'b0) begin nFail++; $display("[TB] FAIL par_before: got %b, expected 0", parity_err); end
    doRead(16'h0010);
    nAssert++; if (parity_err !== 1'b1) begin nFail++; $display("[TB] FAIL par_set: got %b, expected 1", parity_err); end
    nAssert++; if (rdBuf[1] !== 16'hA000) begin nFail++; $display("[TB] FAIL par_data_unchanged: got %h, expected A000", rdBuf[1]); end
    repeat (3) @(negedge clk);
    doRead(16'h0020);
    nAssert++; if (parity_err !== 1'b1) begin nFail++; $display("[TB] FAIL par_sticky: got %b, expected 1", parity_err); end
    rst = 1'b1;
    @(negedge clk);
    nAssert++; if (parity_err !== 1'b0) begin nFail++; $display("[TB] FAIL par_cleared: got %b, expected 0", parity_err); end
    rst = 1'b0;
    @(negedge clk);
`else
    doRead(16'h0010);
    nAssert++; if (rdBuf[0] !== 16'hA000) begin nFail++; $display("[TB] FAIL nopar_read: got %h, expected A000", rdBuf[0]); end
    nAssert++; if (parity_err !== 1'b0) begin nFail++; $display("[TB] FAIL nopar_flag: got %b, expected 0", parity_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_write_stall();
    test_read_burst();
    test_reset_mid_burst();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
